// File: rtl/apb_mc_pkg.sv
// Shared types for the multi-slave APB master: FSM states, response status
// encoding and a width helper.
package apb_mc_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  typedef enum logic [1:0] {ST_OK, ST_SLVERR, ST_DECERR, ST_TIMEOUT} rsp_st_e;

  // ceil(log2(n)), never below 1 so single-entry selects still get a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/apb_mc_decode.sv
// Slave-index to one-hot select decode, plus the per-slave return mux.
module apb_mc_decode #(
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]             dec_idx_i,
  output logic [NUM_SLAVES-1:0]        psel_o,
  output logic                         oor_o,
  input  logic [SEL_W-1:0]             mux_idx_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]        pready_i,
  input  logic [NUM_SLAVES-1:0]        pslverr_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         ready_o,
  output logic                         err_o
);

  // Compare-per-slave so an index past NUM_SLAVES never slices off the bus.
  always_comb begin
    psel_o  = '0;
    oor_o   = 1'b1;
    rdata_o = '0;
    ready_o = 1'b0;
    err_o   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dec_idx_i == SEL_W'(i)) begin
        psel_o[i] = 1'b1;
        oor_o     = 1'b0;
      end
      if (mux_idx_i == SEL_W'(i)) begin
        rdata_o = prdata_i[i*DATA_W +: DATA_W];
        ready_o = pready_i[i];
        err_o   = pslverr_i[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_mc.sv
// Multi-slave APB master: valid/ready command in, SETUP/ACCESS on the bus,
// one response pulse per command with slave/decode/timeout status.
module apb_master_mc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  input  logic [DATA_W/8-1:0]          cmd_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);
  import apb_mc_pkg::*;

  localparam int SEL_W  = clog2_min1(NUM_SLAVES);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = clog2_min1(TIMEOUT + 1);

  state_e                state_q;
  rsp_st_e               rsp_st_q;
  logic                  rdy_q, dec_pend_q, rsp_valid_q;
  logic [SEL_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_SLAVES-1:0] psel_q;
  logic                  penable_q, pwrite_q;
  logic [ADDR_W-1:0]     paddr_q;
  logic [DATA_W-1:0]     pwdata_q, rsp_rdata_q;
  logic [STRB_W-1:0]     pstrb_q;

  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  dec_oor, sel_ready, sel_err;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  done, tmo, accept;

  apb_mc_decode #(.DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES), .SEL_W(SEL_W)) u_dec (
    .dec_idx_i (cmd_addr[ADDR_W-1 -: SEL_W]),
    .psel_o    (dec_onehot),
    .oor_o     (dec_oor),
    .mux_idx_i (idx_q),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr),
    .rdata_o   (sel_rdata),
    .ready_o   (sel_ready),
    .err_o     (sel_err)
  );

  assign done   = (state_q == S_ACCESS) && sel_ready;
  assign tmo    = (TIMEOUT != 0) && (state_q == S_ACCESS) && !sel_ready &&
                  (cnt_q == CNT_W'(TIMEOUT - 1));
  // A decode error accepted on a completion edge is reported one cycle late,
  // so hold off new commands until that pulse has gone out.
  assign cmd_ready = rdy_q && !dec_pend_q && ((state_q == S_IDLE) || done);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q     <= S_IDLE;
      rsp_st_q    <= ST_OK;
      rdy_q       <= 1'b0;
      dec_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
    end else begin
      rdy_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_st_q    <= ST_OK;
      dec_pend_q  <= 1'b0;
      if (dec_pend_q) begin
        rsp_valid_q <= 1'b1;
        rsp_st_q    <= ST_DECERR;
      end
      case (state_q)
        S_IDLE: ;
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (sel_ready) begin
            rsp_valid_q <= 1'b1;
            rsp_st_q    <= sel_err ? ST_SLVERR : ST_OK;
            rsp_rdata_q <= (!pwrite_q && !sel_err) ? sel_rdata : '0;
            cnt_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else if (tmo) begin
            rsp_valid_q <= 1'b1;
            rsp_st_q    <= ST_TIMEOUT;
            cnt_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (accept) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
        pstrb_q  <= cmd_write ? cmd_strb : '0;
        if (dec_oor) begin
          if (state_q == S_IDLE) begin
            rsp_valid_q <= 1'b1;
            rsp_st_q    <= ST_DECERR;
          end else begin
            dec_pend_q <= 1'b1;
          end
        end else begin
          idx_q   <= cmd_addr[ADDR_W-1 -: SEL_W];
          psel_q  <= dec_onehot;
          state_q <= S_SETUP;
        end
      end
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = (rsp_st_q != ST_OK);
  assign rsp_timeout = (rsp_st_q == ST_TIMEOUT);

endmodule

// File: tb/tb_apb_master_mc.sv
// Bench for apb_master_mc: vector table over a 4-slave instance, hand
// sequences for back-to-back/reset, and a 3-slave instance for decode errors.
module tb_apb_master_mc;
  localparam int TMO = 8;

  logic        pclk, preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [127:0] prdata;
  logic [3:0]  pready, pslverr;

  logic        c3_valid, c3_ready, c3_write;
  logic [31:0] c3_addr, c3_wdata;
  logic [3:0]  c3_strb;
  logic        rsp3_valid, rsp3_err, rsp3_timeout;
  logic [31:0] rsp3_rdata;
  logic [2:0]  psel3;
  logic        penable3, pwrite3;
  logic [31:0] paddr3, pwdata3;
  logic [3:0]  pstrb3;
  logic [95:0] prdata3;
  logic [2:0]  pready3, pslverr3;

  apb_master_mc #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_master_mc #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT(TMO)) dut3 (
    .pclk(pclk), .preset(preset),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_write(c3_write),
    .cmd_addr(c3_addr), .cmd_wdata(c3_wdata), .cmd_strb(c3_strb),
    .rsp_valid(rsp3_valid), .rsp_rdata(rsp3_rdata), .rsp_err(rsp3_err), .rsp_timeout(rsp3_timeout),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
    .pstrb(pstrb3), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;   // >= TMO means the slave never answers
    logic [31:0] rdata;
    logic        slverr;
    logic [3:0]  exp_psel;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   rsp_cnt = 0;
  int   apb_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic er, input logic tm);
    exp_t e;
    e.rdata = rd; e.err = er; e.tmo = tm;
    sb.push_back(e);
  endtask

  // Scoreboard: every response pulse pops the oldest expectation.
  always @(negedge pclk) begin : mon
    exp_t e;
    if (preset && psel != 4'b0) apb_cyc++;
    if (preset && rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected got=1 exp=0 t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_rdata", rsp_rdata, e.rdata);
        chk("sb_err", rsp_err, e.err);
        chk("sb_tmo", rsp_timeout, e.tmo);
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_vec(input vec_t v);
    int idx, n;
    idx = int'(v.addr[31:30]);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb;
    for (int s = 0; s < 4; s++) begin
      prdata[s*32 +: 32] = $urandom;
      pready[s] = 1'b1;   // non-selected slaves look ready and erroring
      pslverr[s] = 1'b1;
    end
    prdata[idx*32 +: 32] = v.rdata;
    pready[idx] = 1'b0;
    pslverr[idx] = 1'b0;
    #1 chk("ready_idle", cmd_ready, 1'b1);
    @(posedge pclk);
    push_exp(v.exp_rdata, v.exp_err, v.exp_tmo);
    #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_psel", psel, v.exp_psel);
    chk("setup_penable", penable, 1'b0);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", pwrite, v.write);
    chk("setup_pwdata", pwdata, v.wdata);
    chk("setup_pstrb", pstrb, v.write ? v.strb : 4'b0);
    chk("setup_ready", cmd_ready, 1'b0);
    @(posedge pclk); #1;
    n = (v.waits < TMO) ? v.waits + 1 : TMO;
    for (int k = 0; k < n; k++) begin
      chk("acc_penable", penable, 1'b1);
      chk("acc_psel", psel, v.exp_psel);
      chk("acc_paddr", paddr, v.addr);
      chk("acc_pwdata", pwdata, v.wdata);
      chk("acc_pstrb", pstrb, v.write ? v.strb : 4'b0);
      pready[idx]  = (k == v.waits);
      pslverr[idx] = (k == v.waits) ? v.slverr : 1'b0;
      #1 chk("acc_cmd_ready", cmd_ready, (k == v.waits));
      @(posedge pclk); #1;
    end
    pready = 4'b0; pslverr = 4'b0;
    chk("end_psel", psel, 4'b0);
    chk("end_penable", penable, 1'b0);
    chk("end_rsp_valid", rsp_valid, 1'b1);
    @(posedge pclk); #1;
    chk("pulse_one_cycle", rsp_valid, 1'b0);
  endtask

  vec_t vt[7];
  int   r0, a0;

  initial begin
    vt[0] = '{1'b0, 32'h4000_0010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 4'b0010, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[1] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'b0101, 3, 32'h9999_9999, 1'b0, 4'b0001, 32'h0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 32'hC000_0100, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b1, 4'b1000, 32'h0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 99, 32'h1357_9BDF, 1'b0, 4'b0100, 32'h0, 1'b1, 1'b1};
    vt[4] = '{1'b0, 32'h8000_0024, 32'h0, 4'h0, 1, 32'h0BAD_C0DE, 1'b0, 4'b0100, 32'h0BAD_C0DE, 1'b0, 1'b0};
    vt[5] = '{1'b1, 32'hC000_0008, 32'hA5A5_A5A5, 4'hF, 0, 32'h2468_ACE0, 1'b1, 4'b1000, 32'h0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, TMO-1, 32'h1111_2222, 1'b0, 4'b0001, 32'h1111_2222, 1'b0, 1'b0};

    preset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    prdata = '0; pready = '0; pslverr = '0;
    c3_valid = 1'b0; c3_write = 1'b0; c3_addr = '0; c3_wdata = '0; c3_strb = '0;
    prdata3 = '0; pready3 = '0; pslverr3 = '0;

    // Reset state, and ready only after the first clock following release
    @(posedge pclk); @(posedge pclk); #3;
    chk("rst_psel", psel, 4'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    preset = 1'b1;
    #1 chk("rel_cmd_ready_pre_clk", cmd_ready, 1'b0);
    @(posedge pclk); #1;
    chk("rel_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Back-to-back: read slave 0, then write slave 2 accepted on completion
    r0 = rsp_cnt; a0 = apb_cyc;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040; cmd_strb = 4'h0;
    prdata[31:0] = 32'h5555_AAAA; pready = 4'b0;
    @(posedge pclk);
    push_exp(32'h5555_AAAA, 1'b0, 1'b0);
    #1;
    cmd_write = 1'b1; cmd_addr = 32'h8000_0044; cmd_wdata = 32'h0F0F_0F0F; cmd_strb = 4'b0011;
    chk("b2b_setupA_psel", psel, 4'b0001);
    #1 chk("b2b_setupA_ready", cmd_ready, 1'b0);
    @(posedge pclk); #1;
    chk("b2b_accA_penable", penable, 1'b1);
    pready[0] = 1'b1;
    #1 chk("b2b_compl_ready", cmd_ready, 1'b1);
    @(posedge pclk);
    push_exp(32'h0, 1'b0, 1'b0);
    #1;
    cmd_valid = 1'b0;
    chk("b2b_setupB_psel", psel, 4'b0100);
    chk("b2b_setupB_penable", penable, 1'b0);
    chk("b2b_setupB_pwrite", pwrite, 1'b1);
    chk("b2b_setupB_pwdata", pwdata, 32'h0F0F_0F0F);
    chk("b2b_setupB_pstrb", pstrb, 4'b0011);
    chk("b2b_rspA", rsp_valid, 1'b1);
    pready = 4'b0100;
    @(posedge pclk); #1;
    chk("b2b_accB_penable", penable, 1'b1);
    @(posedge pclk); #1;
    pready = 4'b0;
    chk("b2b_end_psel", psel, 4'b0);
    @(posedge pclk); #1;
    chk("b2b_apb_cycles", apb_cyc - a0, 4);
    chk("b2b_rsp_pulses", rsp_cnt - r0, 2);

    // Reset during ACCESS: APB outputs drop at once, no response
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0080;
    cmd_wdata = 32'hFEED_FACE; cmd_strb = 4'hF; pready = 4'b0;
    @(posedge pclk); push_exp(32'h0, 1'b0, 1'b0);
    #1 cmd_valid = 1'b0;
    @(posedge pclk); @(posedge pclk); #1;
    chk("mid_pre_penable", penable, 1'b1);
    r0 = rsp_cnt;
    #2 preset = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_psel", psel, 4'b0);
    chk("mid_rst_penable", penable, 1'b0);
    chk("mid_rst_paddr", paddr, 32'h0);
    chk("mid_rst_pwdata", pwdata, 32'h0);
    chk("mid_rst_pstrb", pstrb, 4'b0);
    chk("mid_rst_pwrite", pwrite, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b0);
    @(posedge pclk); @(posedge pclk); #3;
    preset = 1'b1;
    @(posedge pclk); #1;
    chk("mid_rel_ready", cmd_ready, 1'b1);
    chk("mid_rel_psel", psel, 4'b0);
    @(posedge pclk); #1;
    chk("mid_no_rsp", rsp_cnt - r0, 0);
    run_vec(vt[0]);

    // 3-slave instance: index 3 is a decode error, index 2 is normal
    c3_valid = 1'b1; c3_write = 1'b0; c3_addr = 32'hC000_0000;
    pready3 = 3'b111; prdata3[95:64] = 32'h7777_8888;
    #1 chk("d3_ready", c3_ready, 1'b1);
    @(posedge pclk); #1;
    c3_valid = 1'b0;
    chk("d3_psel", psel3, 3'b0);
    chk("d3_penable", penable3, 1'b0);
    chk("d3_rsp_valid", rsp3_valid, 1'b1);
    chk("d3_rsp_err", rsp3_err, 1'b1);
    chk("d3_rsp_tmo", rsp3_timeout, 1'b0);
    chk("d3_rsp_rdata", rsp3_rdata, 32'h0);
    @(posedge pclk); #1;
    chk("d3_pulse_end", rsp3_valid, 1'b0);
    chk("d3_psel_quiet", psel3, 3'b0);
    c3_valid = 1'b1; c3_addr = 32'h8000_000C; c3_strb = 4'hF; c3_wdata = 32'h0;
    @(posedge pclk); #1;
    c3_valid = 1'b0;
    chk("n3_setup_psel", psel3, 3'b100);
    chk("n3_setup_paddr", paddr3, 32'h8000_000C);
    chk("n3_setup_pwrite", pwrite3, 1'b0);
    chk("n3_setup_pstrb", pstrb3, 4'b0);
    chk("n3_setup_pwdata", pwdata3, 32'h0);
    @(posedge pclk); #1;
    chk("n3_acc_penable", penable3, 1'b1);
    @(posedge pclk); #1;
    chk("n3_rsp_valid", rsp3_valid, 1'b1);
    chk("n3_rsp_rdata", rsp3_rdata, 32'h7777_8888);
    chk("n3_rsp_err", rsp3_err, 1'b0);
    chk("n3_rsp_tmo", rsp3_timeout, 1'b0);

    repeat (3) @(posedge pclk);
    #1 chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
